csa_adder_pipe: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 16-bit combinational carry-select adder.
- Splits a WIDTH-bit operation into BLK-bit carry-select blocks. Each pipeline stage resolves BLK_PER_STG blocks and registers the carry between stages.
- Uses a valid/ready handshake in both directions, so it can sit in a datapath with backpressure.
- Adds subtract mode, a signed-overflow flag and a pass-through tag.

---
 rtl/csa_adder_pipe.sv | 132 +++++++++++++
 tb/tb_csa_adder_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_adder_pipe.sv
// Pipelined carry-select adder/subtractor.
// WIDTH is split into BLK-bit carry-select blocks; each stage resolves
// BLK_PER_STG of them and registers the carry for the next stage.
// WIDTH must be a multiple of BLK*BLK_PER_STG.
// The whole pipe advances as one unit under a valid/ready handshake.

// One carry-select block: both candidate sums are formed up front so only
// the final select sits on the rippling carry path.
module csa_blk #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           cin,
   output logic [BLK-1:0] sum,
   output logic           cout
);
   logic [BLK:0] s0, s1;

   // candidate sums for carry-in 0 and 1, selected by the incoming carry
   always_comb begin
      s0 = {1'b0, a} + {1'b0, b};
      s1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
      {cout, sum} = cin ? s1 : s0;
   end
endmodule

module csa_adder_pipe #(
   parameter int WIDTH       = 32,
   parameter int BLK         = 4,
   parameter int BLK_PER_STG = 2,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);
   localparam int S    = BLK * BLK_PER_STG;
   localparam int NSTG = WIDTH / S;

   // One pipeline slot. a/b hold the conditioned operands: only the slices
   // not yet consumed matter downstream, the lower bits go dead and are
   // trimmed by synthesis. sum fills in one slice per stage.
   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] sum;
      logic             cy;
      logic             ovf;
      logic [TAG_W-1:0] tag;
   } stg_t;

   logic [NSTG:0] vld_pipe;
   stg_t          stg_q [NSTG+1];   // [0] = accepted op, [k+1] = after stage k
   stg_t          stg_d [NSTG];     // combinational result of stage k
   stg_t          acc_d;
   logic          advance;

   assign advance  = !vld_pipe[NSTG] || out_ready;
   assign in_ready = advance && rst_n;

   // subtract is A + ~B + 1; carry-in is ignored in subtract mode
   always_comb begin
      acc_d     = '0;
      acc_d.a   = in_a;
      acc_d.b   = in_sub ? ~in_b : in_b;
      acc_d.cy  = in_sub | in_cin;
      acc_d.tag = in_tag;
   end

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      logic [BLK_PER_STG:0]              cc;
      logic [BLK_PER_STG-1:0][BLK-1:0]   ss;
      stg_t                              nx;

      assign cc[0] = stg_q[k].cy;

      for (genvar j = 0; j < BLK_PER_STG; j++) begin : g_blk
         csa_blk #(.BLK(BLK)) u_blk (
            .a    (stg_q[k].a[k*S + j*BLK +: BLK]),
            .b    (stg_q[k].b[k*S + j*BLK +: BLK]),
            .cin  (cc[j]),
            .sum  (ss[j]),
            .cout (cc[j+1])
         );
      end

      // merge this slice's sum/carry into the slot; the last stage also
      // derives overflow from carry-in vs carry-out of the MSB
      always_comb begin
         nx                = stg_q[k];
         nx.sum[k*S +: S]  = ss;
         nx.cy             = cc[BLK_PER_STG];
         nx.ovf            = 1'b0;
         if (k == NSTG-1)
            nx.ovf = cc[BLK_PER_STG] ^ stg_q[k].a[WIDTH-1] ^ stg_q[k].b[WIDTH-1]
                   ^ ss[BLK_PER_STG-1][BLK-1];
      end

      assign stg_d[k] = nx;
   end

   // whole pipe shifts together on advance; reset drops every in-flight op
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         for (int k = 0; k <= NSTG; k++) stg_q[k] <= '0;
      end else if (advance) begin
         vld_pipe <= {vld_pipe[NSTG-1:0], in_valid};
         stg_q[0] <= acc_d;
         for (int k = 0; k < NSTG; k++) stg_q[k+1] <= stg_d[k];
      end
   end

   assign out_valid = vld_pipe[NSTG];
   assign out_sum   = stg_q[NSTG].sum;
   assign out_cout  = stg_q[NSTG].cy;
   assign out_ovf   = stg_q[NSTG].ovf;
   assign out_tag   = stg_q[NSTG].tag;
endmodule

// File: tb/tb_csa_adder_pipe.sv
// Bench for csa_adder_pipe: directed cases on the default 32-bit build,
// plus random streams on 16-bit and 64-bit builds, all scoreboard-checked.
module tb_csa_adder_pipe;
   localparam int W   = 32;
   localparam int TW  = 4;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, in_cin, in_sub;
   logic          out_valid, out_ready, out_cout, out_ovf;
   logic [W-1:0]  in_a, in_b, out_sum;
   logic [TW-1:0] in_tag, out_tag;
   logic          sweep_go = 1'b0;

   int checks = 0;
   int errors = 0;
   int npop   = 0;
   logic [W+TW+1:0] exp_q [$];   // {tag, ovf, cout, sum}
   logic [W+TW+1:0] sb_e;

   csa_adder_pipe u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
   );

   function automatic logic [W+TW+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub,
                                             input logic [TW-1:0] tag);
      logic [W:0]   full;
      logic [W-1:0] s;
      logic         c, o;
      if (sub) begin
         full = {1'b0, a} - {1'b0, b};
         s = full[W-1:0];
         c = ~full[W];
         o = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end else begin
         full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         s = full[W-1:0];
         c = full[W];
         o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      return {tag, o, c, s};
   endfunction

   // scoreboard for the 32-bit instance
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            npop++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got sum=%h tag=%h, required no output", out_sum, out_tag);
            end else begin
               sb_e = exp_q.pop_front();
               if ({out_tag, out_ovf, out_cout, out_sum} !== sb_e) begin
                  errors++;
                  $display("FAIL sb_result: got tag/ovf/cout/sum=%h, required %h",
                           {out_tag, out_ovf, out_cout, out_sum}, sb_e);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub, in_tag));
      end
   end

   // present one op and hold it until accepted (called at posedge+1)
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic [TW-1:0] tag);
      bit ok = 1'b0;
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required accept");
      end
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready);
      end
      checks++;
      if ({out_valid, out_sum, out_cout, out_ovf, out_tag} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b tag=%h, required all 0",
                  out_valid, out_sum, out_cout, out_ovf, out_tag);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_add();
      int n;
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'hA);
      wait_out(n);
      checks++;
      if (n != LAT) begin
         errors++; $display("FAIL add_latency: got %0d, required %0d", n, LAT);
      end
      checks++;
      if ({out_sum, out_cout, out_ovf, out_tag} !== {32'h0, 1'b1, 1'b0, 4'hA}) begin
         errors++;
         $display("FAIL add_wrap: got sum=%h c=%b o=%b tag=%h, required sum=0 c=1 o=0 tag=a",
                  out_sum, out_cout, out_ovf, out_tag);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_flags();
      logic [W-1:0] ta [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'd10};
      logic [W-1:0] tb [6] = '{32'd1,         32'd1,         32'd7, 32'd0,        32'd0,        32'd3};
      logic         tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic         ts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] es [6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h0001_0000, 32'h0, 32'd7};
      logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic         eo [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      int n;
      for (int i = 0; i < 6; i++) begin
         send(ta[i], tb[i], tc[i], ts[i], i[TW-1:0]);
         wait_out(n);
         checks++;
         if (!out_valid || {out_sum, out_cout, out_ovf, out_tag} !== {es[i], ec[i], eo[i], i[TW-1:0]}) begin
            errors++;
            $display("FAIL flags_%0d: got v=%b sum=%h c=%b o=%b tag=%h, required sum=%h c=%b o=%b tag=%h",
                     i, out_valid, out_sum, out_cout, out_ovf, out_tag, es[i], ec[i], eo[i], i[TW-1:0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      int base = npop;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send($urandom, $urandom, 1'($urandom_range(0, 1)), i[0], i[TW-1:0]);
         end
         begin
            logic [W+TW+1:0] snap;
            int n = 0;
            while (!out_valid && n < 30) begin
               @(posedge clk);
               #1;
               n++;
            end
            out_ready = 1'b0;
            snap = {out_tag, out_ovf, out_cout, out_sum};
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               checks++;
               if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_tag, out_ovf, out_cout, out_sum} !== snap) begin
                  errors++;
                  $display("FAIL stall_hold_%0d: got rdy=%b v=%b out=%h, required rdy=0 v=1 out=%h",
                           c, in_ready, out_valid, {out_tag, out_ovf, out_cout, out_sum}, snap);
               end
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      for (int c = 0; c < 30 && npop - base < 8; c++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (npop - base != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: got %0d results (%0d pending), required 8 (0 pending)",
                  npop - base, exp_q.size());
      end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      int n;
      for (int i = 1; i <= 3; i++) send($urandom, $urandom, 1'b0, 1'b0, i[TW-1:0]);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_in_ready: got %b, required 0", in_ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      checks++;
      if ({out_valid, out_sum, out_cout, out_ovf, out_tag} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: got v=%b sum=%h tag=%h, required all 0", out_valid, out_sum, out_tag);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL midrst_ghost: got %0d valid cycles, required 0", seen);
      end
      @(posedge clk);
      #1;
      send(32'd123, 32'd456, 1'b0, 1'b0, 4'h5);
      wait_out(n);
      checks++;
      if (n != LAT || out_sum !== 32'd579 || out_tag !== 4'h5) begin
         errors++;
         $display("FAIL midrst_new_op: got lat=%0d sum=%h tag=%h, required lat=%0d sum=243 tag=5",
                  n, out_sum, out_tag, LAT);
      end
      @(posedge clk);
      #1;
   endtask

   // random streams on two other geometries
   for (genvar g = 0; g < 2; g++) begin : sw
      localparam int SW = (g == 0) ? 16 : 64;
      localparam int SB = (g == 0) ? 4  : 8;
      localparam int SP = (g == 0) ? 1  : 4;
      logic iv, ir, ic, is, ov, orr, oc, oo;
      logic [SW-1:0] ia, ib, os, sres;
      logic [TW-1:0] it, ot;
      logic [SW:0] full;
      logic [SW+TW+1:0] q [$];
      logic [SW+TW+1:0] e;
      logic done = 1'b0;
      int npush = 0;
      int nout = 0;

      csa_adder_pipe #(.WIDTH(SW), .BLK(SB), .BLK_PER_STG(SP), .TAG_W(TW)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(iv), .in_ready(ir),
         .in_a(ia), .in_b(ib), .in_cin(ic), .in_sub(is), .in_tag(it),
         .out_valid(ov), .out_ready(orr),
         .out_sum(os), .out_cout(oc), .out_ovf(oo), .out_tag(ot)
      );

      always @(negedge clk) begin
         if (rst_n && ov && orr) begin
            checks++;
            nout++;
            if (q.size() == 0) begin
               errors++; $display("FAIL sweep%0d_unexpected: got sum=%h, required no output", SW, os);
            end else begin
               e = q.pop_front();
               if ({ot, oo, oc, os} !== e) begin
                  errors++;
                  $display("FAIL sweep%0d_result: got %h, required %h", SW, {ot, oo, oc, os}, e);
               end
            end
         end
         if (rst_n && iv && ir) begin
            if (is) begin
               full = {1'b0, ia} - {1'b0, ib};
               sres = full[SW-1:0];
               q.push_back({it, (ia[SW-1] != ib[SW-1]) && (sres[SW-1] != ia[SW-1]), ~full[SW], sres});
            end else begin
               full = {1'b0, ia} + {1'b0, ib} + {{SW{1'b0}}, ic};
               sres = full[SW-1:0];
               q.push_back({it, (ia[SW-1] == ib[SW-1]) && (sres[SW-1] != ia[SW-1]), full[SW], sres});
            end
            npush++;
         end
      end

      initial begin
         logic [63:0] r;
         iv = 1'b0; orr = 1'b1; ia = '0; ib = '0; ic = 1'b0; is = 1'b0; it = '0;
         wait (sweep_go);
         @(posedge clk);
         #1;
         for (int c = 0; c < 20000 && npush < 1000; c++) begin
            r = {$urandom, $urandom};
            ia = r[SW-1:0];
            r = {$urandom, $urandom};
            ib = r[SW-1:0];
            if ($urandom_range(0, 7) == 0) ib = ~ia;
            ic  = 1'($urandom_range(0, 1));
            is  = 1'($urandom_range(0, 1));
            it  = c[TW-1:0];
            iv  = ($urandom_range(0, 9) < 7);
            orr = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
         end
         iv = 1'b0;
         orr = 1'b1;
         for (int c = 0; c < 100 && nout < npush; c++) begin
            @(posedge clk);
            #1;
         end
         checks++;
         if (nout != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL sweep%0d_count: got %0d results (%0d pending), required 1000 (0 pending)",
                     SW, nout, q.size());
         end
         done = 1'b1;
      end
   end

   task automatic test_sweep();
      sweep_go = 1'b1;
      for (int c = 0; c < 30000 && !(sw[0].done && sw[1].done); c++) @(posedge clk);
      if (!(sw[0].done && sw[1].done)) begin
         checks++; errors++;
         $display("FAIL sweep_timeout: got done=%b%b, required 11", sw[1].done, sw[0].done);
      end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: got no finish by 800000, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
      out_ready = 1'b1;
      test_reset();
      test_add();
      test_flags();
      test_back_to_back();
      test_reset_midflight();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
